// File: rtl/sb_debug_target.sv
// sb_debug_target: system-bus target exposing a word-addressed scratch RAM
// to the JTAG debug initiator. Single-word and burst reads/writes inside a
// 2^ADDR_WORDS_LOG2-word window at BASE_ADDR. Every output is zero while the
// block is not responding, so outputs can be OR-combined onto the bus.
//
// Ports:
//   sb_clock_i             system clock (rising edge)
//   sb_reset_i             asynchronous active-high reset
//   sb_address_data_i      address in begin cycle, write data afterwards
//   sb_byte_enables_i      write byte enables, latched at begin
//   sb_burst_size_i        burst length minus one, latched at begin
//   sb_read_n_write_i      1 = read, latched at begin
//   sb_begin_transaction_i transaction start strobe
//   sb_end_transaction_i   initiator end / abort
//   sb_data_valid_i        write word present
//   sb_address_data_o      read data (0 unless sb_data_valid_o)
//   sb_data_valid_o        read word valid
//   sb_end_transaction_o   target end of read burst or error
//   sb_busy_o              write wait-state stall
//   sb_error_o             misaligned transaction rejected
module sb_debug_target #(
   parameter logic [31:0] BASE_ADDR       = 32'h5000_0000,
   parameter int unsigned ADDR_WORDS_LOG2 = 8,
   parameter int unsigned WRITE_WAIT      = 0
) (
   input  logic        sb_clock_i,
   input  logic        sb_reset_i,
   input  logic [31:0] sb_address_data_i,
   input  logic [3:0]  sb_byte_enables_i,
   input  logic [7:0]  sb_burst_size_i,
   input  logic        sb_read_n_write_i,
   input  logic        sb_begin_transaction_i,
   input  logic        sb_end_transaction_i,
   input  logic        sb_data_valid_i,
   output logic [31:0] sb_address_data_o,
   output logic        sb_data_valid_o,
   output logic        sb_end_transaction_o,
   output logic        sb_busy_o,
   output logic        sb_error_o
);

   localparam int unsigned AW    = ADDR_WORDS_LOG2;
   localparam int unsigned DEPTH = 2 ** AW;

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_WAIT, S_READ, S_RDONE, S_ERR
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [3:0]    be_q, be_d;
   logic          wdone_q, wdone_d;
   logic [1:0]    wait_q, wait_d;
   logic          rvalid_q, rvalid_d;
   logic [31:0]   dout_q, dout_d;
   logic          dv_q, dv_d;
   logic          end_q, end_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;
   logic [31:0]   rdata_q;
   logic          sel_c, wr_en_c, rd_en_c;

   logic [31:0]   mem [DEPTH];

   // Window decode on the upper address bits
   assign sel_c = (sb_address_data_i[31:AW+2] == BASE_ADDR[31:AW+2]);

   // Next-state and registered-output logic
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      be_d     = be_q;
      wdone_d  = wdone_q;
      wait_d   = wait_q;
      rvalid_d = 1'b0;
      dv_d     = rvalid_q;
      dout_d   = rvalid_q ? rdata_q : '0;
      end_d    = 1'b0;
      busy_d   = 1'b0;
      err_d    = 1'b0;
      wr_en_c  = 1'b0;
      rd_en_c  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (sb_begin_transaction_i && sel_c) begin
               if (sb_address_data_i[1:0] != 2'b00) begin
                  state_d = S_ERR;
               end else begin
                  idx_d   = sb_address_data_i[AW+1:2];
                  cnt_d   = sb_burst_size_i;
                  be_d    = sb_byte_enables_i;
                  wdone_d = 1'b0;
                  wait_d  = 2'd0;
                  state_d = sb_read_n_write_i ? S_READ : S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (sb_end_transaction_i) begin
               state_d = S_IDLE;
            end else if (sb_data_valid_i && !wdone_q) begin
               wr_en_c = 1'b1;
               idx_d   = idx_q + AW'(1);
               if (cnt_q == 8'd0) wdone_d = 1'b1;
               else               cnt_d   = cnt_q - 8'd1;
               if (WRITE_WAIT != 0) begin
                  busy_d  = 1'b1;
                  wait_d  = 2'(WRITE_WAIT - 1);
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (sb_end_transaction_i) begin
               state_d = S_IDLE;
            end else if (wait_q == 2'd0) begin
               state_d = S_WRITE;
            end else begin
               busy_d = 1'b1;
               wait_d = wait_q - 2'd1;
            end
         end
         S_READ: begin
            if (sb_end_transaction_i) begin
               // Abort: drop the word in flight and the one already issued
               state_d = S_IDLE;
               dv_d    = 1'b0;
               dout_d  = '0;
            end else begin
               rd_en_c  = 1'b1;
               rvalid_d = 1'b1;
               idx_d    = idx_q + AW'(1);
               if (cnt_q == 8'd0) state_d = S_RDONE;
               else               cnt_d   = cnt_q - 8'd1;
            end
         end
         S_RDONE: begin
            // End strobe follows the last word out of the RAM pipeline
            if (!rvalid_q) begin
               end_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_ERR: begin
            err_d   = 1'b1;
            end_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and output registers
   always_ff @(posedge sb_clock_i or posedge sb_reset_i) begin
      if (sb_reset_i) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         be_q     <= '0;
         wdone_q  <= 1'b0;
         wait_q   <= '0;
         rvalid_q <= 1'b0;
         dout_q   <= '0;
         dv_q     <= 1'b0;
         end_q    <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         be_q     <= be_d;
         wdone_q  <= wdone_d;
         wait_q   <= wait_d;
         rvalid_q <= rvalid_d;
         dout_q   <= dout_d;
         dv_q     <= dv_d;
         end_q    <= end_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   // Synchronous scratch RAM, contents survive reset
   always_ff @(posedge sb_clock_i) begin
      if (wr_en_c) begin
         if (be_q[0]) mem[idx_q][7:0]   <= sb_address_data_i[7:0];
         if (be_q[1]) mem[idx_q][15:8]  <= sb_address_data_i[15:8];
         if (be_q[2]) mem[idx_q][23:16] <= sb_address_data_i[23:16];
         if (be_q[3]) mem[idx_q][31:24] <= sb_address_data_i[31:24];
      end
      if (rd_en_c) rdata_q <= mem[idx_q];
   end

   assign sb_address_data_o    = dout_q;
   assign sb_data_valid_o      = dv_q;
   assign sb_end_transaction_o = end_q;
   assign sb_busy_o            = busy_q;
   assign sb_error_o           = err_q;

endmodule

// File: tb/tb_sb_debug_target.sv
// Directed bench for sb_debug_target: two instances in disjoint windows,
// one without and one with write wait states, sharing the bus inputs.
module tb_sb_debug_target;

   localparam logic [31:0] BASE0 = 32'h5000_0000;
   localparam logic [31:0] BASE2 = 32'h6000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ad_i;
   logic [3:0]  be_i;
   logic [7:0]  bs_i;
   logic        rnw_i, beg_i, end_i, dv_i;
   logic [31:0] ad0_o, ad2_o;
   logic        dv0_o, dv2_o, end0_o, end2_o, busy0_o, busy2_o, err0_o, err2_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sb_debug_target #(.BASE_ADDR(BASE0), .ADDR_WORDS_LOG2(8), .WRITE_WAIT(0)) dut0 (
      .sb_clock_i(clk), .sb_reset_i(rst),
      .sb_address_data_i(ad_i), .sb_byte_enables_i(be_i), .sb_burst_size_i(bs_i),
      .sb_read_n_write_i(rnw_i), .sb_begin_transaction_i(beg_i),
      .sb_end_transaction_i(end_i), .sb_data_valid_i(dv_i),
      .sb_address_data_o(ad0_o), .sb_data_valid_o(dv0_o),
      .sb_end_transaction_o(end0_o), .sb_busy_o(busy0_o), .sb_error_o(err0_o)
   );

   sb_debug_target #(.BASE_ADDR(BASE2), .ADDR_WORDS_LOG2(8), .WRITE_WAIT(2)) dut2 (
      .sb_clock_i(clk), .sb_reset_i(rst),
      .sb_address_data_i(ad_i), .sb_byte_enables_i(be_i), .sb_burst_size_i(bs_i),
      .sb_read_n_write_i(rnw_i), .sb_begin_transaction_i(beg_i),
      .sb_end_transaction_i(end_i), .sb_data_valid_i(dv_i),
      .sb_address_data_o(ad2_o), .sb_data_valid_o(dv2_o),
      .sb_end_transaction_o(end2_o), .sb_busy_o(busy2_o), .sb_error_o(err2_o)
   );

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] o_data(input int w);
      return (w != 0) ? ad2_o : ad0_o;
   endfunction
   function automatic logic o_dv(input int w);
      return (w != 0) ? dv2_o : dv0_o;
   endfunction
   function automatic logic o_end(input int w);
      return (w != 0) ? end2_o : end0_o;
   endfunction
   // Nonzero if any output of the selected instance is active
   function automatic logic [31:0] quiet(input int w);
      if (w != 0) return ad2_o | {28'd0, dv2_o, end2_o, busy2_o, err2_o};
      return ad0_o | {28'd0, dv0_o, end0_o, busy0_o, err0_o};
   endfunction

   // Issue a begin; returns at the negedge of the first transaction cycle
   task automatic start(input logic [31:0] a, input logic rnw, input logic [7:0] bs,
                        input logic [3:0] be);
      ad_i = a; rnw_i = rnw; bs_i = bs; be_i = be; beg_i = 1'b1;
      @(negedge clk);
      beg_i = 1'b0; rnw_i = 1'b0; bs_i = 8'd0; be_i = 4'd0; ad_i = 32'd0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] be, input int n,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] d2, input logic [31:0] d3);
      logic [31:0] d [4];
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      start(a, 1'b0, 8'(n - 1), be);
      for (int k = 0; k < n; k++) begin
         dv_i = 1'b1; ad_i = d[k];
         @(negedge clk);
         chk("wr_busy0", 32'(busy0_o), 32'd0);
      end
      dv_i = 1'b0; ad_i = 32'd0; end_i = 1'b1;
      @(negedge clk);
      end_i = 1'b0;
   endtask

   task automatic rd(input string tag, input int w, input logic [31:0] a, input int bs,
                     input logic [31:0] e0, input logic [31:0] e1,
                     input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      start(a, 1'b1, 8'(bs), 4'h0);
      for (int c = 0; c <= bs + 3; c++) begin
         if (c >= 2 && c <= bs + 2) begin
            chk({tag, "_dv"}, 32'(o_dv(w)), 32'd1);
            chk({tag, "_data"}, o_data(w), e[c-2]);
         end else begin
            chk({tag, "_dv"}, 32'(o_dv(w)), 32'd0);
            chk({tag, "_data0"}, o_data(w), 32'd0);
         end
         chk({tag, "_end"}, 32'(o_end(w)), (c == bs + 3) ? 32'd1 : 32'd0);
         chk({tag, "_other_quiet"}, quiet((w != 0) ? 0 : 1), 32'd0);
         if (c < bs + 3) @(negedge clk);
      end
      @(negedge clk);
      chk({tag, "_end_drop"}, 32'(o_end(w)), 32'd0);
   endtask

   initial begin
      logic [10:0] bseq;
      rst = 1'b1; ad_i = '0; be_i = '0; bs_i = '0; rnw_i = 1'b0;
      beg_i = 1'b0; end_i = 1'b0; dv_i = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("reset_dut0", quiet(0), 32'd0);
      chk("reset_dut2", quiet(1), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Burst write then burst read at BASE+0x10 (words 4..7)
      wr(BASE0 + 32'h10, 4'hF, 4, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
      rd("burst", 0, BASE0 + 32'h10, 3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);

      // Partial byte enables over a zeroed word
      wr(BASE0 + 32'h80, 4'hF, 1, 32'h0, 32'h0, 32'h0, 32'h0);
      wr(BASE0 + 32'h80, 4'b0101, 1, 32'hAABB_CCDD, 32'h0, 32'h0, 32'h0);
      rd("be", 0, BASE0 + 32'h80, 0, 32'h00BB_00DD, 32'h0, 32'h0, 32'h0);

      // Index wraps from word 255 to word 0
      wr(BASE0 + 32'h3F8, 4'hF, 4, 32'hA0A0_0000, 32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003);
      rd("wrap0", 0, BASE0, 1, 32'hA2A2_0002, 32'hA3A3_0003, 32'h0, 32'h0);
      rd("wrap254", 0, BASE0 + 32'h3F8, 1, 32'hA0A0_0000, 32'hA1A1_0001, 32'h0, 32'h0);

      // Misaligned begin: error and end together one cycle later, no write
      start(BASE0 + 32'h12, 1'b0, 8'd0, 4'hF);
      dv_i = 1'b1; ad_i = 32'hBAD0_BAD0;
      chk("err_n_err", 32'(err0_o), 32'd0);
      chk("err_n_end", 32'(end0_o), 32'd0);
      @(negedge clk);
      chk("err_n1_err", 32'(err0_o), 32'd1);
      chk("err_n1_end", 32'(end0_o), 32'd1);
      chk("err_n1_dv", 32'(dv0_o), 32'd0);
      @(negedge clk);
      chk("err_n2_err", 32'(err0_o), 32'd0);
      chk("err_n2_end", 32'(end0_o), 32'd0);
      dv_i = 1'b0; ad_i = 32'd0;
      @(negedge clk);
      rd("err_mem", 0, BASE0 + 32'h10, 0, 32'h1111_1111, 32'h0, 32'h0, 32'h0);

      // Wait states: data_valid held, exactly three words written
      wr(BASE2 + 32'h1C, 4'hF, 1, 32'h7777_7777, 32'h0, 32'h0, 32'h0);
      start(BASE2 + 32'h10, 1'b0, 8'd2, 4'hF);
      bseq = 11'b00110110110;
      for (int c = 0; c <= 10; c++) begin
         chk("ww_busy", 32'(busy2_o), 32'(bseq[c]));
         chk("ww_busy0", 32'(busy0_o), 32'd0);
         dv_i = 1'b1;
         if (c == 0)      ad_i = 32'hC0DE_0001;
         else if (c <= 3) ad_i = 32'hC0DE_0002;
         else if (c <= 6) ad_i = 32'hC0DE_0003;
         else             ad_i = 32'hDEAD_BEEF;
         @(negedge clk);
      end
      dv_i = 1'b0; ad_i = 32'd0; end_i = 1'b1;
      @(negedge clk);
      end_i = 1'b0;
      rd("ww_rd", 1, BASE2 + 32'h10, 3, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'h7777_7777);

      // Read abort: end_i in cycle N+4 kills valid from N+5, no target end
      start(BASE0 + 32'h10, 1'b1, 8'd7, 4'h0);
      for (int c = 0; c <= 10; c++) begin
         if (c >= 2 && c <= 4) begin
            chk("abort_dv", 32'(dv0_o), 32'd1);
            chk("abort_data", ad0_o, 32'h1111_1111 * 32'(c - 1));
         end else begin
            chk("abort_dv", 32'(dv0_o), 32'd0);
            chk("abort_data0", ad0_o, 32'd0);
         end
         chk("abort_end", 32'(end0_o), 32'd0);
         end_i = (c == 4);
         @(negedge clk);
      end
      end_i = 1'b0;

      // Non-selected begin: both instances stay silent
      start(32'h7000_0010, 1'b1, 8'd3, 4'h0);
      for (int c = 0; c < 6; c++) begin
         chk("nosel_dut0", quiet(0), 32'd0);
         chk("nosel_dut2", quiet(1), 32'd0);
         @(negedge clk);
      end

      // Asynchronous reset in the middle of a 16-word read
      start(BASE0 + 32'h10, 1'b1, 8'd15, 4'h0);
      @(negedge clk); @(negedge clk);
      chk("rst_pre_dv", 32'(dv0_o), 32'd1);
      #2 rst = 1'b1;
      #1 chk("rst_async", quiet(0), 32'd0);
      @(negedge clk);
      chk("rst_held", quiet(0), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      rd("rst_rd", 0, BASE0 + 32'h10, 0, 32'h1111_1111, 32'h0, 32'h0, 32'h0);

      // Reset during a write data cycle: word not committed
      wr(BASE0 + 32'h24, 4'hF, 1, 32'h9999_9999, 32'h0, 32'h0, 32'h0);
      start(BASE0 + 32'h24, 1'b0, 8'd0, 4'hF);
      dv_i = 1'b1; ad_i = 32'h5555_AAAA;
      #2 rst = 1'b1;
      @(negedge clk);
      dv_i = 1'b0; ad_i = 32'd0; rst = 1'b0;
      @(negedge clk);
      rd("rst_wr", 0, BASE0 + 32'h24, 0, 32'h9999_9999, 32'h0, 32'h0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
